// File: rtl/stream_demux_1_2.sv
// Packet-aware 1:2 stream demultiplexer: whole packets go to M0 or M1 by D_SEL sampled at
// packet start, through one registered slice per output, with per-output packet counters.
module stream_demux_1_2 #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              D_SEL,
    input  logic              CNT_CLR,
    input  logic [DATA_W-1:0] S_TDATA,
    input  logic              S_TVALID,
    input  logic              S_TLAST,
    output logic              S_TREADY,
    output logic [DATA_W-1:0] M0_TDATA,
    output logic              M0_TVALID,
    output logic              M0_TLAST,
    input  logic              M0_TREADY,
    output logic [DATA_W-1:0] M1_TDATA,
    output logic              M1_TVALID,
    output logic              M1_TLAST,
    input  logic              M1_TREADY,
    output logic              ROUTE,
    output logic              IN_PKT,
    output logic [CNT_W-1:0]  PKT_CNT0,
    output logic [CNT_W-1:0]  PKT_CNT1
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic                route_q, route_d;
    logic                in_pkt_q, in_pkt_d;
    logic                tgt_s;
    logic                acc_s;

    logic                m0_valid_q, m0_valid_d;
    logic                m0_last_q, m0_last_d;
    logic [DATA_W-1:0]   m0_data_q, m0_data_d;
    logic                m1_valid_q, m1_valid_d;
    logic                m1_last_q, m1_last_d;
    logic [DATA_W-1:0]   m1_data_q, m1_data_d;

    logic [CNT_W-1:0]    cnt0_q, cnt0_d;
    logic [CNT_W-1:0]    cnt1_q, cnt1_d;

    // Target selection and input handshake; only the target slice can stall the input.
    always_comb begin
        if (state_q == ST_IDLE) begin
            tgt_s = D_SEL;
        end else begin
            tgt_s = route_q;
        end
        if (tgt_s) begin
            S_TREADY = !m1_valid_q || M1_TREADY;
        end else begin
            S_TREADY = !m0_valid_q || M0_TREADY;
        end
        acc_s = S_TVALID && S_TREADY;
    end

    // FSM state register.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; single-beat packets never leave IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_s && !S_TLAST) begin
                    state_d = ST_PKT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PKT: begin
                if (acc_s && S_TLAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_PKT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: route latched at the first beat, packet-in-progress flag.
    always_comb begin
        route_d  = route_q;
        in_pkt_d = in_pkt_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_s) begin
                    route_d  = D_SEL;
                    in_pkt_d = !S_TLAST;
                end else begin
                    route_d  = route_q;
                    in_pkt_d = in_pkt_q;
                end
            end
            ST_PKT: begin
                if (acc_s && S_TLAST) begin
                    in_pkt_d = 1'b0;
                end else begin
                    in_pkt_d = in_pkt_q;
                end
            end
            default: begin
                route_d  = 1'b0;
                in_pkt_d = 1'b0;
            end
        endcase
    end

    // Route and packet flag registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            route_q  <= 1'b0;
            in_pkt_q <= 1'b0;
        end else begin
            route_q  <= route_d;
            in_pkt_q <= in_pkt_d;
        end
    end

    // Output slice next state: load on an accepted beat for this output, else drain.
    always_comb begin
        m0_valid_d = m0_valid_q;
        m0_last_d  = m0_last_q;
        m0_data_d  = m0_data_q;
        if (acc_s && !tgt_s) begin
            m0_valid_d = 1'b1;
            m0_last_d  = S_TLAST;
            m0_data_d  = S_TDATA;
        end else if (M0_TREADY) begin
            m0_valid_d = 1'b0;
        end else begin
            m0_valid_d = m0_valid_q;
        end

        m1_valid_d = m1_valid_q;
        m1_last_d  = m1_last_q;
        m1_data_d  = m1_data_q;
        if (acc_s && tgt_s) begin
            m1_valid_d = 1'b1;
            m1_last_d  = S_TLAST;
            m1_data_d  = S_TDATA;
        end else if (M1_TREADY) begin
            m1_valid_d = 1'b0;
        end else begin
            m1_valid_d = m1_valid_q;
        end
    end

    // Output slice registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            m0_valid_q <= 1'b0;
            m0_last_q  <= 1'b0;
            m0_data_q  <= {DATA_W{1'b0}};
            m1_valid_q <= 1'b0;
            m1_last_q  <= 1'b0;
            m1_data_q  <= {DATA_W{1'b0}};
        end else begin
            m0_valid_q <= m0_valid_d;
            m0_last_q  <= m0_last_d;
            m0_data_q  <= m0_data_d;
            m1_valid_q <= m1_valid_d;
            m1_last_q  <= m1_last_d;
            m1_data_q  <= m1_data_d;
        end
    end

    // Packet counters; clear has priority over a same-cycle increment, counts wrap.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (CNT_CLR) begin
            cnt0_d = {CNT_W{1'b0}};
            cnt1_d = {CNT_W{1'b0}};
        end else if (acc_s && S_TLAST) begin
            if (tgt_s) begin
                cnt1_d = cnt1_q + CNT_W'(1);
            end else begin
                cnt0_d = cnt0_q + CNT_W'(1);
            end
        end else begin
            cnt0_d = cnt0_q;
            cnt1_d = cnt1_q;
        end
    end

    // Counter registers.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            cnt0_q <= {CNT_W{1'b0}};
            cnt1_q <= {CNT_W{1'b0}};
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign M0_TVALID = m0_valid_q;
    assign M0_TLAST  = m0_last_q;
    assign M0_TDATA  = m0_data_q;
    assign M1_TVALID = m1_valid_q;
    assign M1_TLAST  = m1_last_q;
    assign M1_TDATA  = m1_data_q;
    assign ROUTE     = route_q;
    assign IN_PKT    = in_pkt_q;
    assign PKT_CNT0  = cnt0_q;
    assign PKT_CNT1  = cnt1_q;

    stream_demux_1_2_chk #(.DATA_W(DATA_W)) u_chk0 (
        .clk   (CLK),
        .rst_n (RSTN),
        .valid (M0_TVALID),
        .ready (M0_TREADY),
        .last  (M0_TLAST),
        .data  (M0_TDATA)
    );

    stream_demux_1_2_chk #(.DATA_W(DATA_W)) u_chk1 (
        .clk   (CLK),
        .rst_n (RSTN),
        .valid (M1_TVALID),
        .ready (M1_TREADY),
        .last  (M1_TLAST),
        .data  (M1_TDATA)
    );

endmodule

// Output stream checker: a stalled beat must stay valid and unchanged until taken.
module stream_demux_1_2_chk #(
    parameter int DATA_W = 32
) (
    input logic              clk,
    input logic              rst_n,
    input logic              valid,
    input logic              ready,
    input logic              last,
    input logic [DATA_W-1:0] data
);

    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (valid && !ready) |=> (valid && $stable(data) && $stable(last)));

endmodule

// File: tb/tb_stream_demux_1_2.sv
// Scoreboard bench for stream_demux_1_2: directed packets push expected beats per output,
// a forked monitor pops and compares on every output handshake.
module tb_stream_demux_1_2;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        D_SEL;
    logic        CNT_CLR;
    logic [31:0] S_TDATA;
    logic        S_TVALID;
    logic        S_TLAST;
    logic        S_TREADY;
    logic [31:0] M0_TDATA;
    logic        M0_TVALID;
    logic        M0_TLAST;
    logic        M0_TREADY;
    logic [31:0] M1_TDATA;
    logic        M1_TVALID;
    logic        M1_TLAST;
    logic        M1_TREADY;
    logic        ROUTE;
    logic        IN_PKT;
    logic [15:0] PKT_CNT0;
    logic [15:0] PKT_CNT1;

    // Narrow-counter instance driven by the same stimulus, used for wrap checks.
    logic        w_s_tready;
    logic [31:0] w_m0_tdata;
    logic        w_m0_tvalid;
    logic        w_m0_tlast;
    logic [31:0] w_m1_tdata;
    logic        w_m1_tvalid;
    logic        w_m1_tlast;
    logic        w_route;
    logic        w_in_pkt;
    logic [3:0]  w_cnt0;
    logic [3:0]  w_cnt1;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [32:0] exp0_q[$];
    logic [32:0] exp1_q[$];

    always #5 CLK = ~CLK;

    stream_demux_1_2 #(.DATA_W(32), .CNT_W(16)) dut (
        .CLK(CLK), .RSTN(RSTN), .D_SEL(D_SEL), .CNT_CLR(CNT_CLR),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TREADY(S_TREADY),
        .M0_TDATA(M0_TDATA), .M0_TVALID(M0_TVALID), .M0_TLAST(M0_TLAST), .M0_TREADY(M0_TREADY),
        .M1_TDATA(M1_TDATA), .M1_TVALID(M1_TVALID), .M1_TLAST(M1_TLAST), .M1_TREADY(M1_TREADY),
        .ROUTE(ROUTE), .IN_PKT(IN_PKT), .PKT_CNT0(PKT_CNT0), .PKT_CNT1(PKT_CNT1)
    );

    stream_demux_1_2 #(.DATA_W(32), .CNT_W(4)) dut_w4 (
        .CLK(CLK), .RSTN(RSTN), .D_SEL(D_SEL), .CNT_CLR(CNT_CLR),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TLAST(S_TLAST), .S_TREADY(w_s_tready),
        .M0_TDATA(w_m0_tdata), .M0_TVALID(w_m0_tvalid), .M0_TLAST(w_m0_tlast), .M0_TREADY(M0_TREADY),
        .M1_TDATA(w_m1_tdata), .M1_TVALID(w_m1_tvalid), .M1_TLAST(w_m1_tlast), .M1_TREADY(M1_TREADY),
        .ROUTE(w_route), .IN_PKT(w_in_pkt), .PKT_CNT0(w_cnt0), .PKT_CNT1(w_cnt1)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
        end
    endtask

    // Present one beat, wait (bounded) for acceptance, record where it must appear (-1: dropped).
    task automatic send(input logic [31:0] d, input logic last, input logic sel, input int port);
        bit accepted = 1'b0;
        S_TDATA  = d;
        S_TLAST  = last;
        D_SEL    = sel;
        S_TVALID = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge CLK);
            if (S_TREADY) begin
                accepted = 1'b1;
                break;
            end
        end
        if (!accepted) begin
            total_cnt++;
            $display("FAIL send_timeout: beat 0x%0h not accepted within 50 cycles", d);
        end else if (port == 0) begin
            exp0_q.push_back({last, d});
        end else if (port == 1) begin
            exp1_q.push_back({last, d});
        end
        @(posedge CLK);
        #1;
        S_TVALID = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic pulse_clear();
        CNT_CLR = 1'b1;
        cycles(1);
        CNT_CLR = 1'b0;
    endtask

    initial begin
        RSTN = 1'b0; D_SEL = 1'b0; CNT_CLR = 1'b0;
        S_TDATA = 32'h0; S_TVALID = 1'b0; S_TLAST = 1'b0;
        M0_TREADY = 1'b1; M1_TREADY = 1'b1;

        // Scoreboard monitor: every output handshake must match the next expected beat.
        fork
            forever begin
                @(negedge CLK);
                if (RSTN && M0_TVALID && M0_TREADY) begin
                    if (exp0_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL m0_unexpected: got beat 0x%0h, required no beat", {M0_TLAST, M0_TDATA});
                    end else begin
                        check("m0_beat", {31'h0, M0_TLAST, M0_TDATA}, {31'h0, exp0_q.pop_front()});
                    end
                end
                if (RSTN && M1_TVALID && M1_TREADY) begin
                    if (exp1_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL m1_unexpected: got beat 0x%0h, required no beat", {M1_TLAST, M1_TDATA});
                    end else begin
                        check("m1_beat", {31'h0, M1_TLAST, M1_TDATA}, {31'h0, exp1_q.pop_front()});
                    end
                end
            end
        join_none

        cycles(3);
        check("rst_m0_valid", 64'(M0_TVALID), 64'd0);
        check("rst_m1_valid", 64'(M1_TVALID), 64'd0);
        check("rst_m0_data", 64'(M0_TDATA), 64'd0);
        check("rst_route", 64'(ROUTE), 64'd0);
        check("rst_in_pkt", 64'(IN_PKT), 64'd0);
        check("rst_cnt0", 64'(PKT_CNT0), 64'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        cycles(1);

        // 1: four beats to M0, first beat visible one cycle after accept.
        send(32'h11, 1'b0, 1'b0, 0);
        check("t1_latency_valid", 64'(M0_TVALID), 64'd1);
        check("t1_latency_data", 64'(M0_TDATA), 64'h11);
        send(32'h12, 1'b0, 1'b0, 0);
        send(32'h13, 1'b0, 1'b0, 0);
        send(32'h14, 1'b1, 1'b0, 0);
        cycles(2);
        check("t1_cnt0", 64'(PKT_CNT0), 64'd1);
        check("t1_cnt1", 64'(PKT_CNT1), 64'd0);

        // 2: route latched at packet start, D_SEL toggles ignored.
        send(32'h21, 1'b0, 1'b1, 1);
        check("t2_route_b1", 64'(ROUTE), 64'd1);
        check("t2_in_pkt_b1", 64'(IN_PKT), 64'd1);
        send(32'h22, 1'b0, 1'b0, 1);
        check("t2_in_pkt_b2", 64'(IN_PKT), 64'd1);
        check("t2_route_b2", 64'(ROUTE), 64'd1);
        send(32'h23, 1'b1, 1'b1, 1);
        check("t2_in_pkt_end", 64'(IN_PKT), 64'd0);
        check("t2_route_end", 64'(ROUTE), 64'd1);
        cycles(2);
        check("t2_cnt1", 64'(PKT_CNT1), 64'd1);

        // 3: stalled M1 holds input; M0 traffic still flows past it.
        M1_TREADY = 1'b0;
        send(32'h31, 1'b0, 1'b1, 1);
        S_TDATA = 32'h32; S_TLAST = 1'b1; D_SEL = 1'b1; S_TVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("t3_stall_tready", 64'(S_TREADY), 64'd0);
            check("t3_stall_hold", 64'(M1_TDATA), 64'h31);
        end
        @(posedge CLK);
        #1;
        M1_TREADY = 1'b1;
        send(32'h32, 1'b1, 1'b1, 1);
        M1_TREADY = 1'b0;
        check("t3_m1_holds_b2", {M1_TVALID, M1_TDATA}, {1'b1, 32'h32});
        send(32'h41, 1'b1, 1'b0, 0);
        check("t3_m1_still_held", {M1_TVALID, M1_TDATA}, {1'b1, 32'h32});
        cycles(2);
        M1_TREADY = 1'b1;
        cycles(3);
        check("t3_cnt0", 64'(PKT_CNT0), 64'd2);
        check("t3_cnt1", 64'(PKT_CNT1), 64'd2);

        // 4: back-to-back single-beat packets, fresh D_SEL each time.
        pulse_clear();
        check("t4_clr0", 64'(PKT_CNT0), 64'd0);
        check("t4_clr1", 64'(PKT_CNT1), 64'd0);
        send(32'h51, 1'b1, 1'b0, 0);
        send(32'h52, 1'b1, 1'b1, 1);
        send(32'h53, 1'b1, 1'b0, 0);
        cycles(2);
        check("t4_cnt0", 64'(PKT_CNT0), 64'd2);
        check("t4_cnt1", 64'(PKT_CNT1), 64'd1);

        // 5: wrap of a 4-bit counter and clear winning over increment.
        pulse_clear();
        for (int i = 0; i < 16; i++) begin
            send(32'h80 + 32'(i), 1'b1, 1'b0, 0);
        end
        check("t5_cnt0_w16", 64'(PKT_CNT0), 64'd16);
        check("t5_cnt0_w4_wrap", 64'(w_cnt0), 64'd0);
        CNT_CLR = 1'b1;
        send(32'h90, 1'b1, 1'b0, 0);
        CNT_CLR = 1'b0;
        check("t5_clr_wins_w16", 64'(PKT_CNT0), 64'd0);
        check("t5_clr_wins_w4", 64'(w_cnt0), 64'd0);
        send(32'h91, 1'b1, 1'b0, 0);
        check("t5_after_clr", 64'(PKT_CNT0), 64'd1);
        cycles(2);

        // 6: reset mid-packet drops the partial packet; new packet routes fresh.
        send(32'h71, 1'b0, 1'b0, 0);
        send(32'h72, 1'b0, 1'b0, -1);
        RSTN = 1'b0;
        #1;
        check("t6_rst_m0_valid", 64'(M0_TVALID), 64'd0);
        check("t6_rst_m0_data", 64'(M0_TDATA), 64'd0);
        check("t6_rst_in_pkt", 64'(IN_PKT), 64'd0);
        check("t6_rst_cnt0", 64'(PKT_CNT0), 64'd0);
        cycles(2);
        @(negedge CLK);
        RSTN = 1'b1;
        cycles(1);
        send(32'h61, 1'b0, 1'b1, 1);
        send(32'h62, 1'b1, 1'b1, 1);
        cycles(3);
        check("t6_cnt0", 64'(PKT_CNT0), 64'd0);
        check("t6_cnt1", 64'(PKT_CNT1), 64'd1);
        check("t6_route", 64'(ROUTE), 64'd1);

        check("end_exp0_empty", 64'(exp0_q.size()), 64'd0);
        check("end_exp1_empty", 64'(exp1_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/stream_demux_1_2.md
Name: stream_demux_1_2

Overview:
- Packet-aware 1:2 demultiplexer for the AXI-Stream-style sample path; the splitting counterpart of the 2:1 source selector.
- Routes each incoming packet, whole, to output 0 or output 1.
- The route is chosen by D_SEL, sampled only at the first beat of a packet, so a select change never splits a packet.
- Each output has a one-stage registered slice and a packet counter for software/ILA monitoring.

Parameters:
- DATA_W, 32, width of TDATA on input and both outputs.
- CNT_W, 16, width of each per-output packet counter.

Ports:
- CLK  in  1  single clock for all logic.
- RSTN  in  1  reset, asynchronous assert, active-low.
- D_SEL  in  1  route request: 0 selects M0, 1 selects M1. Sampled at packet start only.
- CNT_CLR  in  1  synchronous clear of both packet counters.
- S_TDATA  in  DATA_W  input beat data.
- S_TVALID  in  1  input beat valid.
- S_TLAST  in  1  last beat of the input packet.
- S_TREADY  out  1  input beat accepted when S_TVALID && S_TREADY.
- M0_TDATA / M0_TVALID / M0_TLAST  out  DATA_W/1/1  output 0 stream.
- M0_TREADY  in  1  output 0 ready.
- M1_TDATA / M1_TVALID / M1_TLAST  out  DATA_W/1/1  output 1 stream.
- M1_TREADY  in  1  output 1 ready.
- ROUTE  out  1  currently latched route.
- IN_PKT  out  1  1 while a packet is in progress.
- PKT_CNT0, PKT_CNT1  out  CNT_W  completed packets forwarded to each output.

Behaviour:
- Reset (RSTN=0, asynchronous) forces the following, regardless of the clock:
  - Mx_TVALID=0, Mx_TLAST=0, Mx_TDATA=0.
  - ROUTE=0, IN_PKT=0, PKT_CNTx=0.
  - FSM goes to IDLE.
- Reset mid-packet drops the partial packet; no further beats of it are forwarded after release.
- Target select tgt:
  - IDLE: tgt = D_SEL.
  - PKT: tgt = ROUTE.
- S_TREADY (combinational) = !Mtgt_TVALID || Mtgt_TREADY.
  - Depends only on the target slice; a stalled non-target output never blocks the other path.
- Accept: acc = S_TVALID && S_TREADY.
- FSM, IDLE:
  - On acc: ROUTE <= D_SEL.
  - If !S_TLAST: go to PKT, IN_PKT <= 1.
  - If S_TLAST (single-beat packet): stay in IDLE.
- FSM, PKT:
  - D_SEL is ignored.
  - On acc && S_TLAST: go to IDLE, IN_PKT <= 0.
- Output slice x (per output):
  - Load: on acc with tgt==x, Mx_TDATA/Mx_TLAST <= S_TDATA/S_TLAST and Mx_TVALID <= 1.
  - Drain: else if Mx_TREADY, Mx_TVALID <= 0.
  - Latency is 1 cycle from accept to Mx_TVALID.
  - Full throughput is 1 beat/cycle while Mx_TREADY is held high.
  - Mx_TDATA/Mx_TLAST stay stable while Mx_TVALID && !Mx_TREADY.
  - The non-target output is never written.
- Counters:
  - PKT_CNTx increments by 1 on acc && S_TLAST && tgt==x.
  - Counts wrap modulo 2^CNT_W (all-ones -> 0).
  - CNT_CLR=1 forces both counters to 0; clear wins over a simultaneous increment (result 0).
- Boundary cases:
  - Back-to-back packets with no idle cycle: the first beat of the next packet samples D_SEL in the same cycle that the previous TLAST is accepted? No. The TLAST cycle uses ROUTE; the next cycle is IDLE and samples D_SEL fresh.
  - S_TVALID deasserting mid-packet: the FSM holds PKT and ROUTE indefinitely.
  - D_SEL toggling every cycle mid-packet: no effect.

Test Plan:
1. Reset then D_SEL=0, send 4-beat packet 0x11..0x14 with M0_TREADY=1 → M0 carries 0x11..0x14, one cycle delayed, TLAST on 0x14; M1_TVALID stays 0; PKT_CNT0=1, PKT_CNT1=0.
2. Start 3-beat packet with D_SEL=1, toggle D_SEL after beat 1 → all 3 beats on M1; ROUTE=1 throughout; IN_PKT high for beats 1-2, then 0.
3. M1_TREADY=0, D_SEL=1, send 2 beats → beat 1 held on M1, S_TREADY=0 until M1_TREADY=1; no data lost or duplicated; a following packet with D_SEL=0 flows to M0 while M1 is still stalled.
4. Three single-beat packets back-to-back with D_SEL=0,1,0 → M0 gets beats 1 and 3, M1 gets beat 2; PKT_CNT0=2, PKT_CNT1=1.
5. CNT_W=4 override, 16 packets to M0 → PKT_CNT0 wraps to 0; CNT_CLR asserted on the cycle of a TLAST accept → counter reads 0.
6. Assert RSTN=0 mid-packet (beat 2 of 5), release, then send a new 2-beat packet with D_SEL=1 → outputs cleared immediately on reset; only the new packet appears, on M1; counters equal 0/1.
